// File: rtl/odom_integrator.sv
// Tick-driven pose integrator: x, y [m] and theta [deg] advanced from global
// velocities through one shared signed multiplier over five clock cycles.
//
// state   | meaning
// IDLE    | waiting for a tick falling edge; pose held
// MUL_VX  | dx = vx * dt
// MUL_VY  | dy = vy * dt
// MUL_WZ  | dthRad = wz * dt
// MUL_DEG | dth = dthRad * 180/pi
// ACCUM   | saturating position add, wrapped theta add, DONE pulse
module odom_integrator #(
  parameter int N_WIDTH   = 17,
  parameter int Q_WIDTH   = 8,
  parameter int DT_Q      = 43,
  parameter int RAD2DEG_Q = 14668
) (
  input  logic                      ODOM_INTEGRATOR_CLOCK_50,
  input  logic                      ODOM_INTEGRATOR_Reset_InLow,
  input  logic                      ODOM_INTEGRATOR_SETBEGIN_InLow,
  input  logic                      ODOM_INTEGRATOR_TICKLOAD_InLow,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_VX_InBus,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_VY_InBus,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_WZ_InBus,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_INITX_InBus,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_INITY_InBus,
  input  logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_INITTHETA_InBus,
  output logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_POSX_OutBus,
  output logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_POSY_OutBus,
  output logic signed [N_WIDTH-1:0] ODOM_INTEGRATOR_THETA_OutBus,
  output logic                      ODOM_INTEGRATOR_BUSY_Out,
  output logic                      ODOM_INTEGRATOR_DONE_Out,
  output logic                      ODOM_INTEGRATOR_SAT_Out,
  output logic                      ODOM_INTEGRATOR_OVERRUN_Out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_VX  = 3'd1,
    MUL_VY  = 3'd2,
    MUL_WZ  = 3'd3,
    MUL_DEG = 3'd4,
    ACCUM   = 3'd5
  } stateT;

  localparam logic signed [N_WIDTH-1:0] DT_K      = N_WIDTH'(DT_Q);
  localparam logic signed [N_WIDTH-1:0] RAD2DEG_K = N_WIDTH'(RAD2DEG_Q);
  localparam logic signed [N_WIDTH:0]   POS_MAX   = (N_WIDTH+1)'((2**(N_WIDTH-1)) - 1);
  localparam logic signed [N_WIDTH:0]   POS_MIN   = (N_WIDTH+1)'(-(2**(N_WIDTH-1)));
  localparam logic signed [N_WIDTH+1:0] TH_HALF   = (N_WIDTH+2)'(180 * (2**Q_WIDTH));
  localparam logic signed [N_WIDTH+1:0] TH_FULL   = (N_WIDTH+2)'(360 * (2**Q_WIDTH));

  stateT state, stateNext;

  logic                      tickPrev;
  logic                      tickEvent;
  logic signed [N_WIDTH-1:0] vxReg, vyReg, wzReg;
  logic signed [N_WIDTH-1:0] dxReg, dyReg, dthRadReg, dthReg;
  logic signed [N_WIDTH-1:0] posX, posY, theta;
  logic                      doneReg, satReg, overrunReg;

  logic signed [N_WIDTH-1:0]   mulA, mulB, mulRes;
  logic signed [2*N_WIDTH-1:0] mulProd;

  logic signed [N_WIDTH:0]   sumX, sumY;
  logic signed [N_WIDTH-1:0] nextX, nextY, nextTheta;
  logic                      satHit;
  logic signed [N_WIDTH+1:0] thSum, thWrapped;

  assign tickEvent = tickPrev & ~ODOM_INTEGRATOR_TICKLOAD_InLow;

  // One multiplier serves all four scaling steps; the operands follow the state.
  always_comb begin
    mulA = vxReg;
    mulB = DT_K;
    case (state)
      MUL_VX:  begin mulA = vxReg;     mulB = DT_K;      end
      MUL_VY:  begin mulA = vyReg;     mulB = DT_K;      end
      MUL_WZ:  begin mulA = wzReg;     mulB = DT_K;      end
      MUL_DEG: begin mulA = dthRadReg; mulB = RAD2DEG_K; end
      default: begin mulA = vxReg;     mulB = DT_K;      end
    endcase
  end

  assign mulProd = (2*N_WIDTH)'(mulA) * (2*N_WIDTH)'(mulB);
  assign mulRes  = N_WIDTH'(mulProd >>> Q_WIDTH);

  always_comb begin
    sumX   = (N_WIDTH+1)'(posX) + (N_WIDTH+1)'(dxReg);
    sumY   = (N_WIDTH+1)'(posY) + (N_WIDTH+1)'(dyReg);
    nextX  = N_WIDTH'(sumX);
    nextY  = N_WIDTH'(sumY);
    satHit = 1'b0;
    if (sumX > POS_MAX) begin
      nextX  = POS_MAX[N_WIDTH-1:0];
      satHit = 1'b1;
    end else if (sumX < POS_MIN) begin
      nextX  = POS_MIN[N_WIDTH-1:0];
      satHit = 1'b1;
    end
    if (sumY > POS_MAX) begin
      nextY  = POS_MAX[N_WIDTH-1:0];
      satHit = 1'b1;
    end else if (sumY < POS_MIN) begin
      nextY  = POS_MIN[N_WIDTH-1:0];
      satHit = 1'b1;
    end
  end

  // A single wrap step suffices because one tick never turns more than 180 deg.
  always_comb begin
    thSum     = (N_WIDTH+2)'(theta) + (N_WIDTH+2)'(dthReg);
    thWrapped = thSum;
    if (thSum > TH_HALF) begin
      thWrapped = thSum - TH_FULL;
    end else if (thSum <= -TH_HALF) begin
      thWrapped = thSum + TH_FULL;
    end
    nextTheta = N_WIDTH'(thWrapped);
  end

  always_comb begin
    stateNext = state;
    if (!ODOM_INTEGRATOR_SETBEGIN_InLow) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (tickEvent) stateNext = MUL_VX;
        MUL_VX:  stateNext = MUL_VY;
        MUL_VY:  stateNext = MUL_WZ;
        MUL_WZ:  stateNext = MUL_DEG;
        MUL_DEG: stateNext = ACCUM;
        ACCUM:   stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge ODOM_INTEGRATOR_CLOCK_50 or negedge ODOM_INTEGRATOR_Reset_InLow) begin
    if (!ODOM_INTEGRATOR_Reset_InLow) begin
      state      <= IDLE;
      tickPrev   <= 1'b0;
      vxReg      <= '0;
      vyReg      <= '0;
      wzReg      <= '0;
      dxReg      <= '0;
      dyReg      <= '0;
      dthRadReg  <= '0;
      dthReg     <= '0;
      posX       <= '0;
      posY       <= '0;
      theta      <= '0;
      doneReg    <= 1'b0;
      satReg     <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      state    <= stateNext;
      tickPrev <= ODOM_INTEGRATOR_TICKLOAD_InLow;
      doneReg  <= 1'b0;
      if (!ODOM_INTEGRATOR_SETBEGIN_InLow) begin
        posX       <= ODOM_INTEGRATOR_INITX_InBus;
        posY       <= ODOM_INTEGRATOR_INITY_InBus;
        theta      <= ODOM_INTEGRATOR_INITTHETA_InBus;
        satReg     <= 1'b0;
        overrunReg <= 1'b0;
      end else begin
        if (tickEvent && state != IDLE) overrunReg <= 1'b1;
        case (state)
          IDLE: begin
            if (tickEvent) begin
              vxReg <= ODOM_INTEGRATOR_VX_InBus;
              vyReg <= ODOM_INTEGRATOR_VY_InBus;
              wzReg <= ODOM_INTEGRATOR_WZ_InBus;
            end
          end
          MUL_VX:  dxReg     <= mulRes;
          MUL_VY:  dyReg     <= mulRes;
          MUL_WZ:  dthRadReg <= mulRes;
          MUL_DEG: dthReg    <= mulRes;
          ACCUM: begin
            posX    <= nextX;
            posY    <= nextY;
            theta   <= nextTheta;
            doneReg <= 1'b1;
            if (satHit) satReg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ODOM_INTEGRATOR_POSX_OutBus  = posX;
  assign ODOM_INTEGRATOR_POSY_OutBus  = posY;
  assign ODOM_INTEGRATOR_THETA_OutBus = theta;
  assign ODOM_INTEGRATOR_BUSY_Out     = (state != IDLE);
  assign ODOM_INTEGRATOR_DONE_Out     = doneReg;
  assign ODOM_INTEGRATOR_SAT_Out      = satReg;
  assign ODOM_INTEGRATOR_OVERRUN_Out  = overrunReg;

endmodule

// File: tb/tb_odom_integrator.sv
// Bench for odom_integrator: a cycle-level arithmetic pose model checked every
// cycle, plus directed scenarios with hand-computed pose values.
module tb_odom_integrator;

  localparam int     N   = 17;
  localparam longint DT  = 43;
  localparam longint R2D = 14668;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic setB = 1'b1;
  logic tick = 1'b1;
  logic signed [N-1:0] vx = '0, vy = '0, wz = '0;
  logic signed [N-1:0] initX = '0, initY = '0, initTh = '0;
  logic signed [N-1:0] posX, posY, theta;
  logic busy, done, sat, overrun;

  always #5 clk = ~clk;

  odom_integrator dut (
    .ODOM_INTEGRATOR_CLOCK_50       (clk),
    .ODOM_INTEGRATOR_Reset_InLow    (rstN),
    .ODOM_INTEGRATOR_SETBEGIN_InLow (setB),
    .ODOM_INTEGRATOR_TICKLOAD_InLow (tick),
    .ODOM_INTEGRATOR_VX_InBus       (vx),
    .ODOM_INTEGRATOR_VY_InBus       (vy),
    .ODOM_INTEGRATOR_WZ_InBus       (wz),
    .ODOM_INTEGRATOR_INITX_InBus    (initX),
    .ODOM_INTEGRATOR_INITY_InBus    (initY),
    .ODOM_INTEGRATOR_INITTHETA_InBus(initTh),
    .ODOM_INTEGRATOR_POSX_OutBus    (posX),
    .ODOM_INTEGRATOR_POSY_OutBus    (posY),
    .ODOM_INTEGRATOR_THETA_OutBus   (theta),
    .ODOM_INTEGRATOR_BUSY_Out       (busy),
    .ODOM_INTEGRATOR_DONE_Out       (done),
    .ODOM_INTEGRATOR_SAT_Out        (sat),
    .ODOM_INTEGRATOR_OVERRUN_Out    (overrun)
  );

  function automatic longint sx17(input longint a);
    logic signed [N-1:0] t;
    t = a[N-1:0];
    return longint'(t);
  endfunction

  function automatic longint scaleDt(input longint v);
    return sx17((v * DT) >>> 8);
  endfunction

  function automatic longint toDeg(input longint r);
    return sx17((r * R2D) >>> 8);
  endfunction

  function automatic longint clampPos(input longint s);
    if (s > 65535) return 65535;
    if (s < -65536) return -65536;
    return s;
  endfunction

  function automatic longint wrapTh(input longint s);
    if (s > 46080) return s - 92160;
    if (s <= -46080) return s + 92160;
    return s;
  endfunction

  // Reference model: counts the five-cycle latency and applies the pose update.
  longint mX = 0, mY = 0, mTh = 0, cVx = 0, cVy = 0, cWz = 0;
  bit     mSat = 0, mOvr = 0, mDone = 0, mPrev = 0;
  int     mCnt = 0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mX <= 0; mY <= 0; mTh <= 0; cVx <= 0; cVy <= 0; cWz <= 0;
      mSat <= 0; mOvr <= 0; mDone <= 0; mPrev <= 0; mCnt <= 0;
    end else begin
      mPrev <= tick;
      mDone <= 0;
      if (!setB) begin
        mX <= longint'(initX); mY <= longint'(initY); mTh <= longint'(initTh);
        mSat <= 0; mOvr <= 0; mCnt <= 0;
      end else if (mCnt > 0) begin
        if (mPrev && !tick) mOvr <= 1;
        mCnt <= mCnt - 1;
        if (mCnt == 1) begin
          mX    <= clampPos(mX + scaleDt(cVx));
          mY    <= clampPos(mY + scaleDt(cVy));
          mTh   <= wrapTh(mTh + toDeg(scaleDt(cWz)));
          mDone <= 1;
          if (clampPos(mX + scaleDt(cVx)) != mX + scaleDt(cVx) ||
              clampPos(mY + scaleDt(cVy)) != mY + scaleDt(cVy)) mSat <= 1;
        end
      end else if (mPrev && !tick) begin
        cVx <= longint'(vx); cVy <= longint'(vy); cWz <= longint'(wz);
        mCnt <= 5;
      end
    end
  end

  int  passCnt = 0, totalCnt = 0, doneCount = 0, d0 = 0, lat = 0;
  bit  cmpEn = 0;

  task automatic check(input string name, input longint act, input longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compareAll();
    check("cyc posX", longint'(posX), mX);
    check("cyc posY", longint'(posY), mY);
    check("cyc theta", longint'(theta), mTh);
    check("cyc busy", longint'(busy), longint'(mCnt != 0));
    check("cyc done", longint'(done), longint'(mDone));
    check("cyc sat", longint'(sat), longint'(mSat));
    check("cyc overrun", longint'(overrun), longint'(mOvr));
  endtask

  task automatic setPose(input int x, input int y, input int th);
    @(negedge clk);
    initX = N'(x); initY = N'(y); initTh = N'(th); setB = 1'b0;
    @(negedge clk);
    setB = 1'b1;
  endtask

  task automatic doTick();
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cmpEn) begin
          compareAll();
          if (done) doneCount++;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    cmpEn = 1;
    #1;
    check("reset posX", longint'(posX), 0);
    check("reset theta", longint'(theta), 0);
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    @(negedge clk) rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Unit velocity along x, with latency and BUSY measured by hand.
    setPose(0, 0, 0);
    vx = 17'sd256; vy = '0; wz = '0;
    d0 = doneCount;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    check("busy after edge k", longint'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("done latency", lat, 5);
    @(negedge clk);
    check("done width", longint'(done), 0);
    check("busy after done", longint'(busy), 0);
    check("posX vx=1.0", longint'(posX), 43);
    check("posY vx=1.0", longint'(posY), 0);
    check("theta vx=1.0", longint'(theta), 0);
    repeat (3) @(negedge clk);
    check("single done", doneCount - d0, 1);

    // Floor rounding of a tiny negative step.
    setPose(0, 0, 0);
    vx = -17'sd1;
    doTick();
    check("posX floor", longint'(posX), -1);

    // Heading integration and wrap across +180 deg.
    setPose(0, 0, 0);
    vx = '0; wz = 17'sd256;
    doTick();
    check("theta wz=1", longint'(theta), 2463);
    setPose(0, 0, 45824);
    doTick();
    check("theta wrap", longint'(theta), -43873);

    // Positive saturation, hold, and clear on load.
    setPose(65000, 0, 0);
    vx = 17'sd25600; wz = '0;
    doTick();
    check("posX sat", longint'(posX), 65535);
    check("sat flag", longint'(sat), 1);
    doTick();
    check("posX sat hold", longint'(posX), 65535);
    setPose(0, 0, 0);
    check("sat cleared", longint'(sat), 0);

    // Second tick two cycles after the first.
    vx = 17'sd256;
    d0 = doneCount;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    repeat (10) @(negedge clk);
    check("overrun flag", longint'(overrun), 1);
    check("overrun posX", longint'(posX), 43);
    check("overrun dones", doneCount - d0, 1);

    // Tick coincident with pose load is dropped.
    d0 = doneCount;
    @(negedge clk);
    initX = 17'sd100; initY = 17'sd200; initTh = 17'sd300;
    setB = 1'b0; tick = 1'b0;
    @(negedge clk) begin setB = 1'b1; tick = 1'b1; end
    repeat (10) @(negedge clk);
    check("coinc posX", longint'(posX), 100);
    check("coinc posY", longint'(posY), 200);
    check("coinc theta", longint'(theta), 300);
    check("coinc overrun clr", longint'(overrun), 0);
    check("coinc no done", doneCount - d0, 0);

    // Tick held low through reset release.
    @(negedge clk) begin rstN = 1'b0; tick = 1'b0; end
    repeat (3) @(negedge clk);
    d0 = doneCount;
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    repeat (10) @(negedge clk);
    check("held tick no done", doneCount - d0, 0);
    check("held tick posX", longint'(posX), 0);

    // Reset during an integration.
    setPose(10, 20, 30);
    vx = 17'sd256; vy = 17'sd256; wz = 17'sd256;
    d0 = doneCount;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    check("midrst posX", longint'(posX), 0);
    check("midrst posY", longint'(posY), 0);
    check("midrst theta", longint'(theta), 0);
    check("midrst busy", longint'(busy), 0);
    @(negedge clk);
    @(negedge clk) rstN = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst no done", doneCount - d0, 0);
    check("midrst posX after", longint'(posX), 0);

    cmpEn = 0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
